// File: rtl/contador_pkg.sv
// contador_pkg: shared constants and elaboration-time helpers for the contador_universal counter family.
// Contents: clog2, direction constants CONT_UP/CONT_DOWN, params_ok parameter range check.
package contador_pkg;

    localparam logic CONT_UP   = 1'b1;
    localparam logic CONT_DOWN = 1'b0;

    function automatic int clog2(input longint unsigned v);
        longint unsigned x;
        int r;
        x = 1;
        r = 0;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int w, input longint m, input int p);
        return (w >= 1) && (w <= 32) && (m >= 2) && (m <= (longint'(1) << w)) && (p >= 1);
    endfunction

endpackage

// File: rtl/contador_prescaler.sv
// contador_prescaler: divides enabled cycles by PRESCALE and flags the last cycle of each period.
// Ports: iClk, iRst_n (sync, active-low), iEn (count this cycle), iClr (restart phase) -> oTick.
module contador_prescaler
    import contador_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iEn,
    input  logic iClr,
    output logic oTick
);

    // PRESCALE=1 still needs a one-bit register; it simply never leaves 0.
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] TOPE = PW'(PRESCALE - 1);

    logic [PW-1:0] fase_d, fase_q;

    assign oTick = fase_q == TOPE;

    always_comb begin
        fase_d = iClr ? '0 : (iEn ? (oTick ? '0 : fase_q + PW'(1)) : fase_q);
    end

    always_ff @(posedge iClk) begin
        fase_q <= !iRst_n ? '0 : fase_d;
    end

endmodule

// File: rtl/contador_universal.sv
// contador_universal: parametrised up/down modulo counter with load, cascadable terminal count and sticky wrap flag.
// Ports: iClk, iRst_n (sync, active-low), iEn, iUp, iLoad, iDato -> oCuenta, oTc (combinational), oDesborde.
// Define CONTADOR_PRESC_EN to build a prescaler so a step happens every PRESCALE enabled cycles.
module contador_universal
    import contador_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULO   = 16,
    parameter int     PRESCALE = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEn,
    input  logic             iUp,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iDato,
    output logic [WIDTH-1:0] oCuenta,
    output logic             oTc,
    output logic             oDesborde
);

    // One extra bit so MODULO = 2**WIDTH and load clamping compare correctly.
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULO - 1);

    if (!params_ok(WIDTH, MODULO, PRESCALE)) begin : g_bad_params
        $error("contador_universal: illegal WIDTH/MODULO/PRESCALE");
    end

    logic [WIDTH-1:0] cuenta_d, cuenta_q;
    logic             desborde_d, desborde_q;
    logic             tick, paso, en_ultimo, en_cero, en_limite;

`ifdef CONTADOR_PRESC_EN
    contador_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iEn   (iEn & ~iLoad),
        .iClr  (iLoad),
        .oTick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign en_ultimo = {1'b0, cuenta_q} == LAST;
    assign en_cero   = cuenta_q == '0;
    assign en_limite = (iUp == CONT_UP) ? en_ultimo : en_cero;
    assign paso      = iEn & ~iLoad & tick;
    // Gated by reset so a cascaded stage never sees a spurious enable while held in reset.
    assign oTc       = iRst_n & paso & en_limite;

    always_comb begin
        cuenta_d   = cuenta_q;
        desborde_d = desborde_q;
        if (iLoad) begin
            cuenta_d   = ({1'b0, iDato} > LAST) ? LAST[WIDTH-1:0] : iDato;
            desborde_d = 1'b0;
        end else if (paso) begin
            cuenta_d   = (iUp == CONT_UP) ? (en_ultimo ? '0 : cuenta_q + WIDTH'(1))
                                          : (en_cero ? LAST[WIDTH-1:0] : cuenta_q - WIDTH'(1));
            desborde_d = desborde_q | en_limite;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cuenta_q   <= '0;
            desborde_q <= 1'b0;
        end else begin
            cuenta_q   <= cuenta_d;
            desborde_q <= desborde_d;
        end
    end

    assign oCuenta   = cuenta_q;
    assign oDesborde = desborde_q;

endmodule

// File: tb/tb_contador_universal.sv
// tb_contador_universal: directed and random checks of contador_universal against an arithmetic reference model.
module tb_contador_universal;

`ifdef CONTADOR_PRESC_EN
    localparam int PEFF = 3;
`else
    localparam int PEFF = 1;
`endif
    localparam int MOD = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] dato = '0;
    logic [3:0] cuenta;
    logic       tc, desb;

    logic       c_rst_n = 1'b0, c_en = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_desb, hi_desb;

    logic       p_rst_n = 1'b0, p_en = 1'b0;
    logic [3:0] p_cuenta;
    logic       p_tc, p_desb;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    bit m_flag = 1'b0;

    contador_universal #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dut (
        .iClk(clk), .iRst_n(rst_n), .iEn(en), .iUp(up), .iLoad(load), .iDato(dato),
        .oCuenta(cuenta), .oTc(tc), .oDesborde(desb)
    );

    contador_universal #(.WIDTH(4), .MODULO(16)) u_lo (
        .iClk(clk), .iRst_n(c_rst_n), .iEn(c_en), .iUp(1'b1), .iLoad(1'b0), .iDato(4'd0),
        .oCuenta(lo_q), .oTc(lo_tc), .oDesborde(lo_desb)
    );

    contador_universal #(.WIDTH(4), .MODULO(16)) u_hi (
        .iClk(clk), .iRst_n(c_rst_n), .iEn(lo_tc), .iUp(1'b1), .iLoad(1'b0), .iDato(4'd0),
        .oCuenta(hi_q), .oTc(hi_tc), .oDesborde(hi_desb)
    );

    contador_universal #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) u_pre (
        .iClk(clk), .iRst_n(p_rst_n), .iEn(p_en), .iUp(1'b1), .iLoad(1'b0), .iDato(4'd0),
        .oCuenta(p_cuenta), .oTc(p_tc), .oDesborde(p_desb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the count is a number modulo MOD; wrap means leaving the range edge.
    function automatic bit m_tc();
        return rst_n && en && !load && (up ? (m_cnt == MOD - 1) : (m_cnt == 0));
    endfunction

    task automatic m_edge();
        if (!rst_n) begin
            m_cnt  = 0;
            m_flag = 1'b0;
        end else if (load) begin
            m_cnt  = (int'(dato) >= MOD) ? MOD - 1 : int'(dato);
            m_flag = 1'b0;
        end else if (en) begin
            if ((up && m_cnt == MOD - 1) || (!up && m_cnt == 0)) m_flag = 1'b1;
            m_cnt = up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic u, input logic l, input logic [3:0] d);
        rst_n = r;
        en    = e;
        up    = u;
        load  = l;
        dato  = d;
        #1 check("tc", {31'd0, tc}, {31'd0, m_tc()});
        @(posedge clk);
        m_edge();
        #1;
        check("cuenta", {28'd0, cuenta}, m_cnt);
        check("desborde", {31'd0, desb}, {31'd0, m_flag});
    endtask

    initial begin
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("rst_cuenta", {28'd0, cuenta}, 0);
        check("rst_desborde", {31'd0, desb}, 0);
        repeat (9) cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check("up_nueve", {28'd0, cuenta}, 9);
        #1 check("tc_nueve", {31'd0, tc}, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check("wrap_cero", {28'd0, cuenta}, 0);
        check("wrap_flag", {31'd0, desb}, 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        en   = 1'b1;
        load = 1'b0;
        #1 check("tc_cero", {31'd0, tc}, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("down_nueve", {28'd0, cuenta}, 9);
        check("down_flag", {31'd0, desb}, 1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd12);
        check("load_sat", {28'd0, cuenta}, 9);
        check("load_flag", {31'd0, desb}, 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
        repeat (5) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            check("hold", {28'd0, cuenta}, 3);
            check("hold_tc", {31'd0, tc}, 0);
        end
        repeat (300) begin
            cycle(1'($urandom_range(15) != 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
                  1'($urandom_range(7) == 0), 4'($urandom));
        end

        c_rst_n = 1'b0;
        @(posedge clk);
        #1 check("cas_rst", {24'd0, hi_q, lo_q}, 0);
        c_rst_n = 1'b1;
        c_en    = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1 if (i % 50 == 0) check("cas_parcial", {24'd0, hi_q, lo_q}, i % 256);
        end
        check("cas_lo", {28'd0, lo_q}, 12);
        check("cas_hi", {28'd0, hi_q}, 2);
        c_en = 1'b0;

        p_rst_n = 1'b0;
        p_en    = 1'b1;
        #1 check("pre_tc_rst", {31'd0, p_tc}, 0);
        @(posedge clk);
        #1 check("pre_rst", {28'd0, p_cuenta}, 0);
        p_rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1 check("pre_nueve", {28'd0, p_cuenta}, (9 / PEFF) % MOD);
        @(posedge clk);
        #1 p_rst_n = 1'b0;
        #1 check("pre_tc_rst2", {31'd0, p_tc}, 0);
        @(posedge clk);
        #1 check("pre_rst2", {28'd0, p_cuenta}, 0);
        p_rst_n = 1'b1;
        repeat (PEFF - 1) @(posedge clk);
        #1 check("pre_espera", {28'd0, p_cuenta}, 0);
        @(posedge clk);
        #1 check("pre_primer", {28'd0, p_cuenta}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
